// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: owns the frame-buffer write port. It runs a full-frame clear
//   out of reset or on request, and otherwise serves two plot clients round-robin.
// Ports: clk/reset, clearReq/clearColor/busyClear, req{0,1}{Valid,X,Y,Color,Ready},
//   writeX/writeY/wrColor/wrEnable to memory, and a dropped pulse for out-of-range plots.
// Latency: one cycle from a transfer to its write. Readies are 0 while clearing,
//   while clearReq is high and during reset.
module pixel_write_arbiter #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearReq,
  input  logic [3:0] clearColor,
  output logic       busyClear,
  input  logic       req0Valid,
  input  logic [9:0] req0X,
  input  logic [9:0] req0Y,
  input  logic [3:0] req0Color,
  output logic       req0Ready,
  input  logic       req1Valid,
  input  logic [9:0] req1X,
  input  logic [9:0] req1Y,
  input  logic [3:0] req1Color,
  output logic       req1Ready,
  output logic [9:0] writeX,
  output logic [9:0] writeY,
  output logic [3:0] wrColor,
  output logic       wrEnable,
  output logic       dropped
);

  typedef enum logic {CLEAR, SERVE} state_t;

  localparam logic [9:0] X_LAST = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0] X_LIM  = 10'(FRAME_WIDTH);
  localparam logic [9:0] Y_LIM  = 10'(FRAME_HEIGHT);

  state_t     state_q;
  logic [9:0] cntX_q, cntY_q;
  logic [3:0] fillColor_q;
  logic       lastGrant_q;
  logic [9:0] writeX_q, writeY_q;
  logic [3:0] wrColor_q;
  logic       wrEnable_q, dropped_q;

  logic       serve_ok;
  logic       gnt0, gnt1, xfer, in_range;
  logic [9:0] selX, selY;
  logic [3:0] selColor;

  // A pending clear wins over plots, so grants are only offered when no clear is requested.
  always_comb begin
    serve_ok = !reset && (state_q == SERVE) && !clearReq;
    // On contention the client that did not win last time gets the port.
    gnt0     = serve_ok && req0Valid && (!req1Valid || lastGrant_q);
    gnt1     = serve_ok && req1Valid && (!req0Valid || !lastGrant_q);
    xfer     = gnt0 || gnt1;
    selX     = gnt1 ? req1X : req0X;
    selY     = gnt1 ? req1Y : req0Y;
    selColor = gnt1 ? req1Color : req0Color;
    in_range = (selX < X_LIM) && (selY < Y_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      cntX_q      <= '0;
      cntY_q      <= '0;
      fillColor_q <= '0;
      lastGrant_q <= 1'b1;
      writeX_q    <= '0;
      writeY_q    <= '0;
      wrColor_q   <= '0;
      wrEnable_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          writeX_q   <= cntX_q;
          writeY_q   <= cntY_q;
          wrColor_q  <= fillColor_q;
          wrEnable_q <= 1'b1;
          dropped_q  <= 1'b0;
          if (cntX_q == X_LAST) begin
            cntX_q <= '0;
            if (cntY_q == Y_LAST) begin
              // Last pixel of the frame: hand the port to the plot clients.
              cntY_q  <= '0;
              state_q <= SERVE;
            end else begin
              cntY_q <= cntY_q + 10'd1;
            end
          end else begin
            cntX_q <= cntX_q + 10'd1;
          end
        end
        default: begin
          if (clearReq) begin
            fillColor_q <= clearColor;
            state_q     <= CLEAR;
            wrEnable_q  <= 1'b0;
            dropped_q   <= 1'b0;
          end else if (xfer) begin
            lastGrant_q <= gnt1;
            if (in_range) begin
              writeX_q   <= selX;
              writeY_q   <= selY;
              wrColor_q  <= selColor;
              wrEnable_q <= 1'b1;
              dropped_q  <= 1'b0;
            end else begin
              // Out-of-range plot is consumed but never reaches memory.
              wrEnable_q <= 1'b0;
              dropped_q  <= 1'b1;
            end
          end else begin
            wrEnable_q <= 1'b0;
            dropped_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busyClear = (state_q == CLEAR);
  assign req0Ready = gnt0;
  assign req1Ready = gnt1;
  assign writeX    = writeX_q;
  assign writeY    = writeY_q;
  assign wrColor   = wrColor_q;
  assign wrEnable  = wrEnable_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
module tb_pixel_write_arbiter;

  localparam int FW = 8;
  localparam int FH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clearReq;
  logic [3:0] clearColor;
  logic       busyClear;
  logic       req0Valid, req1Valid;
  logic [9:0] req0X, req0Y, req1X, req1Y;
  logic [3:0] req0Color, req1Color;
  logic       req0Ready, req1Ready;
  logic [9:0] writeX, writeY;
  logic [3:0] wrColor;
  logic       wrEnable, dropped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_write_arbiter #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .reset(reset),
    .clearReq(clearReq), .clearColor(clearColor), .busyClear(busyClear),
    .req0Valid(req0Valid), .req0X(req0X), .req0Y(req0Y), .req0Color(req0Color), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1X(req1X), .req1Y(req1Y), .req1Color(req1Color), .req1Ready(req1Ready),
    .writeX(writeX), .writeY(writeY), .wrColor(wrColor), .wrEnable(wrEnable), .dropped(dropped)
  );

  typedef struct {
    logic       v0;
    logic [9:0] x0, y0;
    logic [3:0] c0;
    logic       v1;
    logic [9:0] x1, y1;
    logic [3:0] c1;
    logic       r0, r1, we;
    logic [9:0] wx, wy;
    logic [3:0] wc;
    logic       dr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v0, input int x0, input int y0, input int c0,
                              input logic v1, input int x1, input int y1, input int c1,
                              input logic r0, input logic r1, input logic we,
                              input int wx, input int wy, input int wc, input logic dr);
    vec_t v;
    v.v0 = v0; v.x0 = 10'(x0); v.y0 = 10'(y0); v.c0 = 4'(c0);
    v.v1 = v1; v.x1 = 10'(x1); v.y1 = 10'(y1); v.c1 = 4'(c1);
    v.r0 = r0; v.r1 = r1; v.we = we;
    v.wx = 10'(wx); v.wy = 10'(wy); v.wc = 4'(wc); v.dr = dr;
    return v;
  endfunction

  // Expects FW*FH row-major writes of colour col, readies low throughout,
  // busyClear dropping together with the last write.
  task automatic run_clear(input logic [3:0] col);
    for (int i = 0; i < FW * FH; i++) begin
      chk("clr_rdy0", 32'(req0Ready), 32'd0);
      chk("clr_rdy1", 32'(req1Ready), 32'd0);
      tick();
      chk("clr_we", 32'(wrEnable), 32'd1);
      chk("clr_x", 32'(writeX), 32'(i % FW));
      chk("clr_y", 32'(writeY), 32'(i / FW));
      chk("clr_col", 32'(wrColor), 32'(col));
      chk("clr_drop", 32'(dropped), 32'd0);
      chk("clr_busy", 32'(busyClear), (i == FW * FH - 1) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_we", 32'(wrEnable), 32'd0);
    chk("rst_x", 32'(writeX), 32'd0);
    chk("rst_y", 32'(writeY), 32'd0);
    chk("rst_col", 32'(wrColor), 32'd0);
    chk("rst_drop", 32'(dropped), 32'd0);
    chk("rst_busy", 32'(busyClear), 32'd1);
    chk("rst_rdy0", 32'(req0Ready), 32'd0);
    chk("rst_rdy1", 32'(req1Ready), 32'd0);
  endtask

  initial begin
    // Both-valid alternation first: after reset lastGrant=1, so req0 wins first.
    vecs.push_back(mk(1,1,1,10, 1,2,2,11, 1,0, 1, 1,1,10, 0));
    vecs.push_back(mk(1,1,1,10, 1,2,2,11, 0,1, 1, 2,2,11, 0));
    vecs.push_back(mk(1,1,1,10, 1,2,2,11, 1,0, 1, 1,1,10, 0));
    vecs.push_back(mk(1,1,1,10, 1,2,2,11, 0,1, 1, 2,2,11, 0));
    // Single client and a back-to-back stream.
    vecs.push_back(mk(1,3,2,5,  0,0,0,0,  1,0, 1, 3,2,5,  0));
    vecs.push_back(mk(1,0,0,1,  0,0,0,0,  1,0, 1, 0,0,1,  0));
    vecs.push_back(mk(1,1,0,2,  0,0,0,0,  1,0, 1, 1,0,2,  0));
    vecs.push_back(mk(1,2,0,3,  0,0,0,0,  1,0, 1, 2,0,3,  0));
    vecs.push_back(mk(1,3,0,4,  0,0,0,0,  1,0, 1, 3,0,4,  0));
    // Idle.
    vecs.push_back(mk(0,0,0,0,  0,0,0,0,  0,0, 0, 0,0,0,  0));
    // Out-of-range drops, then the corner pixel written normally.
    vecs.push_back(mk(0,0,0,0,  1,8,0,3,  0,1, 0, 0,0,0,  1));
    vecs.push_back(mk(0,0,0,0,  1,0,4,3,  0,1, 0, 0,0,0,  1));
    vecs.push_back(mk(0,0,0,0,  1,7,3,3,  0,1, 1, 7,3,3,  0));
    // lastGrant is 1 now, so req0 wins contention.
    vecs.push_back(mk(1,5,1,7,  1,6,2,8,  1,0, 1, 5,1,7,  0));
    vecs.push_back(mk(0,0,0,0,  0,0,0,0,  0,0, 0, 0,0,0,  0));

    reset = 1'b1; clearReq = 1'b0; clearColor = 4'd0;
    req0Valid = 1'b1; req0X = 10'd4; req0Y = 10'd1; req0Color = 4'd6;
    req1Valid = 1'b1; req1X = 10'd5; req1Y = 10'd2; req1Color = 4'd7;
    clearColor = 4'd12; clearReq = 1'b1;   // must be ignored while clearing

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_outputs();
    end
    reset = 1'b0;
    run_clear(4'd0);
    req0Valid = 1'b0; req1Valid = 1'b0; clearReq = 1'b0;

    foreach (vecs[k]) begin
      req0Valid = vecs[k].v0; req0X = vecs[k].x0; req0Y = vecs[k].y0; req0Color = vecs[k].c0;
      req1Valid = vecs[k].v1; req1X = vecs[k].x1; req1Y = vecs[k].y1; req1Color = vecs[k].c1;
      #1;
      chk($sformatf("v%0d_rdy0", k), 32'(req0Ready), 32'(vecs[k].r0));
      chk($sformatf("v%0d_rdy1", k), 32'(req1Ready), 32'(vecs[k].r1));
      tick();
      chk($sformatf("v%0d_we", k), 32'(wrEnable), 32'(vecs[k].we));
      chk($sformatf("v%0d_drop", k), 32'(dropped), 32'(vecs[k].dr));
      chk($sformatf("v%0d_busy", k), 32'(busyClear), 32'd0);
      if (vecs[k].we) begin
        chk($sformatf("v%0d_x", k), 32'(writeX), 32'(vecs[k].wx));
        chk($sformatf("v%0d_y", k), 32'(writeY), 32'(vecs[k].wy));
        chk($sformatf("v%0d_col", k), 32'(wrColor), 32'(vecs[k].wc));
      end
    end

    // Clear request with a plot pending: clear wins, plot waits for the frame.
    req0Valid = 1'b1; req0X = 10'd4; req0Y = 10'd1; req0Color = 4'd6;
    req1Valid = 1'b0;
    clearReq = 1'b1; clearColor = 4'd9;
    #1;
    chk("clrreq_rdy0", 32'(req0Ready), 32'd0);
    chk("clrreq_rdy1", 32'(req1Ready), 32'd0);
    tick();
    clearReq = 1'b0; clearColor = 4'd2;
    chk("clrreq_we", 32'(wrEnable), 32'd0);
    chk("clrreq_busy", 32'(busyClear), 32'd1);
    run_clear(4'd9);
    #1;
    chk("post_clr_rdy0", 32'(req0Ready), 32'd1);
    tick();
    req0Valid = 1'b0;
    chk("post_clr_we", 32'(wrEnable), 32'd1);
    chk("post_clr_x", 32'(writeX), 32'd4);
    chk("post_clr_y", 32'(writeY), 32'd1);
    chk("post_clr_col", 32'(wrColor), 32'd6);

    // Reset in the middle of a colour-9 clear.
    clearReq = 1'b1; clearColor = 4'd9;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_we", 32'(wrEnable), 32'd1);
    chk("mid_col", 32'(wrColor), 32'd9);
    reset = 1'b1;
    req0Valid = 1'b1;
    tick();
    chk_reset_outputs();
    tick();
    chk_reset_outputs();
    reset = 1'b0;
    run_clear(4'd0);

    // Reset asserted while serving: readies must drop with reset itself.
    req0Valid = 1'b1;
    #1;
    chk("serve_rdy0", 32'(req0Ready), 32'd1);
    reset = 1'b1;
    #1;
    chk("serve_rst_rdy0", 32'(req0Ready), 32'd0);
    tick();
    chk_reset_outputs();
    reset = 1'b0;
    req0Valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
